// File: rtl/reg_dump_streamer_if.sv
// Word stream from reg_dump_streamer to a logging consumer (bench, UART bridge, trace FIFO).
interface reg_dump_streamer_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IDX_W  = 5
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_header;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_header,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_header,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/reg_dump_streamer.sv
// Snapshots the register file and PC on an end-of-run trigger, then streams a header word
// (PC) followed by every register, one word per valid/ready handshake.
module reg_dump_streamer #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 64,
  localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       trigger,
  input  logic                       except_in,
  input  logic [DATA_W-1:0]          pc_in,
  input  logic [NUM_REGS*DATA_W-1:0] debug_reg_in,
  input  logic                       rearm,
  reg_dump_streamer_if.master        dump,
  output logic                       out_cause,
  output logic                       busy,
  output logic                       dump_done
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {StIdle, StHeader, StStream, StDone} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              capture;
  logic              cause_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] snap_q [NUM_REGS];

  // State and stream index; reset aborts any dump in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Exception cause is kept through DONE and only cleared by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cause_q <= 1'b0;
    end else if (capture) begin
      cause_q <= except_in;
    end
  end

  // Single-edge snapshot of PC and register file; never read outside HEADER/STREAM.
  always_ff @(posedge clock) begin
    if (capture) begin
      pc_q <= pc_in;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        snap_q[i] <= debug_reg_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and stream outputs; outputs are zero whenever no word is offered.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    capture         = 1'b0;
    dump.out_valid  = 1'b0;
    dump.out_header = 1'b0;
    dump.out_data   = '0;
    dump.out_index  = '0;
    dump.out_last   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          capture = 1'b1;
          state_d = StHeader;
        end
      end
      StHeader: begin
        dump.out_valid  = 1'b1;
        dump.out_header = 1'b1;
        dump.out_data   = pc_q;
        if (dump.out_ready) begin
          state_d = StStream;
          idx_d   = '0;
        end
      end
      StStream: begin
        dump.out_valid = 1'b1;
        dump.out_data  = snap_q[idx_q];
        dump.out_index = idx_q;
        dump.out_last  = (idx_q == LastIdx);
        if (dump.out_ready) begin
          // Index stops at the last register; the final handshake leaves for DONE.
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StDone: begin
        if (rearm) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_cause = cause_q;
  assign busy      = (state_q == StHeader) || (state_q == StStream);
  assign dump_done = (state_q == StDone);

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Directed bench for reg_dump_streamer: a queue-based model of the expected word stream is
// checked every cycle, plus literal expectations for the headline scenarios.
module tb_reg_dump_streamer;

  localparam int unsigned NR = 32;
  localparam int unsigned DW = 64;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           trigger = 1'b0;
  logic           except_in = 1'b0;
  logic [DW-1:0]  pc_in = '0;
  logic [NR*DW-1:0] debug_reg_in = '0;
  logic           rearm = 1'b0;
  logic           out_cause, busy, dump_done;

  reg_dump_streamer_if #(.DATA_W(DW), .IDX_W(5)) bus ();

  reg_dump_streamer #(.NUM_REGS(NR), .DATA_W(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .trigger      (trigger),
    .except_in    (except_in),
    .pc_in        (pc_in),
    .debug_reg_in (debug_reg_in),
    .rearm        (rearm),
    .dump         (bus.master),
    .out_cause    (out_cause),
    .busy         (busy),
    .dump_done    (dump_done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  idx;
    logic        hdr;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int    m_state = 0;  // 0 idle, 1 dumping, 2 done
  logic  m_cause = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_q.delete();
      m_state = 0;
      m_cause = 1'b0;
    end else begin
      case (m_state)
        0: if (trigger) begin
          exp_q.push_back('{data: pc_in, idx: 5'd0, hdr: 1'b1, last: 1'b0});
          for (int i = 0; i < int'(NR); i++) begin
            exp_q.push_back('{data: debug_reg_in[i*DW +: DW], idx: 5'(i), hdr: 1'b0,
                              last: (i == int'(NR) - 1)});
          end
          m_cause = except_in;
          m_state = 1;
        end
        1: if (bus.out_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_state = 2;
        end
        2: if (rearm) m_state = 0;
        default: m_state = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    word_t w;
    logic  exp_v;
    bit    ok;
    if (cmp_en) begin
      exp_v = (exp_q.size() != 0);
      w = exp_v ? exp_q[0] : '0;
      ok = (bus.out_valid == exp_v) && (busy == (m_state == 1)) &&
           (dump_done == (m_state == 2)) && (out_cause == m_cause);
      if (exp_v) begin
        ok = ok && (bus.out_data == w.data) && (bus.out_index == w.idx) &&
             (bus.out_header == w.hdr) && (bus.out_last == w.last);
      end
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL stream_cmp t=%0t got v=%0b d=%h i=%0d h=%0b l=%0b busy=%0b done=%0b cause=%0b want v=%0b d=%h i=%0d h=%0b l=%0b busy=%0b done=%0b cause=%0b",
                    $time, bus.out_valid, bus.out_data, bus.out_index, bus.out_header,
                    bus.out_last, busy, dump_done, out_cause, exp_v, w.data, w.idx, w.hdr,
                    w.last, (m_state == 1), (m_state == 2), m_cause);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
  endtask

  task automatic set_regs(input logic [63:0] base, input bit same);
    for (int i = 0; i < int'(NR); i++) begin
      debug_reg_in[i*DW +: DW] = same ? base : base + 64'(i);
    end
  endtask

  task automatic wait_index(input int k);
    int c = 0;
    while (!(bus.out_valid && !bus.out_header && int'(bus.out_index) == k) && c < 100) begin
      tick();
      c++;
    end
    if (c >= 100) begin
      n_checks++;
      $display("FAIL wait_index: index %0d not reached, got %0d", k, bus.out_index);
    end
  endtask

  task automatic wait_done();
    int c = 0;
    bus.out_ready = 1'b1;
    while (!dump_done && c < 100) begin
      tick();
      c++;
    end
    if (c >= 100) begin
      n_checks++;
      $display("FAIL wait_done: dump_done got %0b want 1", dump_done);
    end
  endtask

  // Counts the contiguous run of valid words from now, with ready held high.
  task automatic count_dump(output int n, output int nlast, output int lastidx,
                            output logic [63:0] d31);
    n = 0; nlast = 0; lastidx = -1; d31 = '0;
    bus.out_ready = 1'b1;
    while (bus.out_valid && n < 40) begin
      n++;
      if (bus.out_last) begin
        nlast++;
        lastidx = int'(bus.out_index);
      end
      if (!bus.out_header && bus.out_index == 5'd31) d31 = bus.out_data;
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, nlast, lastidx;
    logic [63:0] d31;
    bus.out_ready = 1'b1;
    #3 reset = 1'b0;
    cmp_en = 1'b1;
    tick();
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(dump_done), 64'd0);
    check("reset_cause", 64'(out_cause), 64'd0);
    reset = 1'b1;
    tick();

    // 1: basic dump
    set_regs(64'h1000, 1'b0);
    pc_in = 64'h0040_0020;
    pulse_trigger();
    check("hdr_valid", 64'(bus.out_valid), 64'd1);
    check("hdr_flag", 64'(bus.out_header), 64'd1);
    check("hdr_pc", bus.out_data, 64'h0040_0020);
    check("hdr_index", 64'(bus.out_index), 64'd0);
    count_dump(n, nlast, lastidx, d31);
    check("basic_len", 64'(n), 64'd33);
    check("basic_nlast", 64'(nlast), 64'd1);
    check("basic_lastidx", 64'(lastidx), 64'd31);
    check("basic_d31", d31, 64'h101F);
    check("basic_done", 64'(dump_done), 64'd1);

    // 2: backpressure at index 5
    pulse_rearm();
    pulse_trigger();
    wait_index(5);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_hold_data", bus.out_data, 64'h1005);
      check("bp_hold_index", 64'(bus.out_index), 64'd5);
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_next_index", 64'(bus.out_index), 64'd6);
    check("bp_next_data", bus.out_data, 64'h1006);
    wait_done();

    // 3: snapshot isolation
    pulse_rearm();
    pulse_trigger();
    set_regs(64'hDEAD, 1'b1);
    wait_index(3);
    check("snap_d3", bus.out_data, 64'h1003);
    wait_index(20);
    check("snap_d20", bus.out_data, 64'h1014);
    wait_done();
    set_regs(64'h1000, 1'b0);

    // 4: exception cause, retrigger while busy ignored
    pulse_rearm();
    except_in = 1'b1;
    pulse_trigger();
    except_in = 1'b0;
    check("cause_hdr", 64'(out_cause), 64'd1);
    wait_index(2);
    pulse_trigger();
    wait_done();
    check("cause_done", 64'(out_cause), 64'd1);
    tick();
    check("retrig_ignored", 64'({dump_done, busy}), 64'b10);
    pulse_rearm();
    pulse_trigger();
    check("cause_clear", 64'(out_cause), 64'd0);
    wait_done();

    // 5: asynchronous reset mid-dump
    pulse_rearm();
    pulse_trigger();
    wait_index(12);
    #2 reset = 1'b0;
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(dump_done), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    pulse_trigger();
    check("rst_restart_hdr", 64'({bus.out_valid, bus.out_header}), 64'b11);
    check("rst_restart_pc", bus.out_data, 64'h0040_0020);
    wait_done();

    // 6: DONE hold, rearm with simultaneous trigger, full redump
    for (int c = 0; c < 20; c++) begin
      trigger = c[0];
      tick();
      check("done_hold", 64'({dump_done, bus.out_valid}), 64'b10);
    end
    trigger = 1'b0;
    rearm = 1'b1;
    trigger = 1'b1;
    tick();
    rearm = 1'b0;
    trigger = 1'b0;
    tick();
    check("rearm_idle", 64'({busy, dump_done, bus.out_valid}), 64'b000);
    pulse_trigger();
    count_dump(n, nlast, lastidx, d31);
    check("redump_len", 64'(n), 64'd33);
    check("redump_done", 64'(dump_done), 64'd1);

    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_dump_streamer.md
Name: reg_dump_streamer

Overview:
- Downstream consumer of the 64-bit full machine's debug register port and end-of-run conditions (done or exception).
- On a trigger, snapshots the 32x64 register file plus the current PC and streams them out one word per handshake.
- The word stream is a valid/ready interface, so a bench, UART bridge or trace FIFO can log final machine state in hardware rather than via simulation-only dumps.

Parameters:
- NUM_REGS, 32, number of architectural registers streamed; index width is clog2(NUM_REGS).
- DATA_W, 64, register and PC width.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- trigger  input  1  end-of-run request (done OR except from the machine).
- except_in  input  1  exception flag, sampled with trigger.
- pc_in  input  DATA_W  current PC, sampled with trigger.
- debug_reg_in  input  NUM_REGS*DATA_W  flattened register file; reg i occupies bits [i*DATA_W +: DATA_W].
- rearm  input  1  single-cycle pulse returning the block from DONE to IDLE.
- out_valid  output  1  out_data, out_index, out_header, out_last are valid.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_data  output  DATA_W  PC (header word) or register value.
- out_index  output  5  register number; 0 on the header word.
- out_header  output  1  current word is the header (PC).
- out_last  output  1  current word is register NUM_REGS-1.
- out_cause  output  1  captured except_in; held for the whole dump.
- busy  output  1  high in HEADER or STREAM.
- dump_done  output  1  high in DONE.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE. All outputs are 0. The snapshot buffer is not required to clear.
- States: IDLE, HEADER, STREAM, DONE.
- IDLE:
  - On a clock edge with trigger=1, capture pc_in, except_in and all of debug_reg_in into internal registers, then go to HEADER.
  - The capture is a single-edge snapshot; later input changes have no effect on the dump.
- HEADER:
  - out_valid=1, out_header=1, out_data=captured PC, out_index=0, out_last=0.
  - On handshake, go to STREAM with idx=0.
- STREAM:
  - out_valid=1, out_header=0, out_data=snapshot[idx], out_index=idx, out_last=(idx==NUM_REGS-1).
  - On handshake, idx increments. If out_last was set, go to DONE instead.
- DONE:
  - out_valid=0 and dump_done=1, held indefinitely.
  - rearm=1 on an edge returns to IDLE. A trigger in the same cycle as rearm is ignored.
- Latency: the first out_valid is asserted on the edge following trigger capture (1 cycle). With out_ready held high, a dump is exactly NUM_REGS+1=33 consecutive cycles.
- Handshake rules:
  - While out_valid && !out_ready, out_data, out_index, out_header and out_last hold stable.
  - out_valid never drops before the handshake.
- trigger outside IDLE is ignored; it is not queued.
- trigger held high continuously causes a new capture only on re-entry to IDLE after rearm.
- out_cause is updated only at capture and stays valid through DONE. It clears only on reset.
- busy = (state==HEADER || state==STREAM).
- Reset asserted mid-dump aborts immediately: out_valid=0, state=IDLE. There is no partial completion.
- idx is NUM_REGS-wide safe; it never wraps past NUM_REGS-1.

Test Plan:
1. Basic dump:
   - Stimulus: reg i = 64'h1000+i, pc_in=64'h0040_0020, pulse trigger, out_ready=1.
   - Response: header 0x400020 with out_header=1, then indices 0..31 with data 0x1000..0x101F.
   - out_last only on index 31; dump_done rises the cycle after; 33 valid cycles total.
2. Backpressure:
   - Stimulus: drop out_ready for 3 cycles at index 5.
   - Response: out_data=0x1005 and out_index=5 hold stable; index 6 follows only after ready returns; no word is lost or duplicated.
3. Snapshot isolation:
   - Stimulus: after trigger, overwrite all debug_reg_in with 64'hDEAD.
   - Response: the streamed values remain 0x1000+i.
4. Exception cause:
   - Stimulus: trigger with except_in=1.
   - Response: out_cause=1 from the header through DONE; a retrigger while busy is ignored.
   - After rearm plus a trigger with except_in=0, out_cause=0.
5. Reset mid-dump:
   - Stimulus: assert reset at index 12 (asynchronously, between edges).
   - Response: out_valid, busy and dump_done go 0 immediately.
   - After release, a trigger restarts from the header.
6. DONE hold and rearm:
   - Stimulus: no rearm for 20 cycles with trigger pulses.
   - Response: dump_done stays 1 and out_valid stays 0.
   - rearm returns the block to IDLE; the next trigger produces a full 33-word dump.
